// File: rtl/bip_pkg.sv
// Shared widths, default memory depth and debug-port state encoding for the BIP data memory.
package bip_pkg;

    localparam int unsigned NB_ADDR   = 11;
    localparam int unsigned NB_DATA   = 16;
    localparam int unsigned NB_CNT    = 16;
    localparam int unsigned RAM_DEPTH = 2048;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } dbg_state_t;

endpackage

// File: rtl/bip_dmem_dbg_port.sv
// Cycle-stealing debug port: latches a request, waits for a CPU-idle cycle,
// issues a one-cycle access strobe and holds the four-phase ack.
module bip_dmem_dbg_port #(
    parameter int unsigned NB_ADDR = bip_pkg::NB_ADDR,
    parameter int unsigned NB_DATA = bip_pkg::NB_DATA
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_dbg_req,
    input  logic               i_dbg_we,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    input  logic [NB_DATA-1:0] i_dbg_wdata,
    input  logic               i_cpu_busy,
    input  logic [NB_DATA-1:0] i_acc_rdata,
    output logic               o_acc_c,
    output logic               o_acc_we,
    output logic [NB_ADDR-1:0] o_acc_addr,
    output logic [NB_DATA-1:0] o_acc_wdata,
    output logic               o_dbg_ack,
    output logic [NB_DATA-1:0] o_dbg_rdata
);

    bip_pkg::dbg_state_t r_state;
    bip_pkg::dbg_state_t w_next;
    logic                r_we;
    logic [NB_ADDR-1:0]  r_addr;
    logic [NB_DATA-1:0]  r_wdata;
    logic                r_ack;
    logic [NB_DATA-1:0]  r_rdata;

    // The access fires only in a WAIT cycle the CPU leaves free.
    always_comb begin
        w_next  = r_state;
        o_acc_c = 1'b0;
        case (r_state)
            bip_pkg::IDLE: if (i_dbg_req) w_next = bip_pkg::WAIT;
            bip_pkg::WAIT: begin
                if (!i_cpu_busy) begin
                    o_acc_c = 1'b1;
                    w_next  = bip_pkg::ACK;
                end
            end
            bip_pkg::ACK:  if (!i_dbg_req) w_next = bip_pkg::IDLE;
            default:       w_next = bip_pkg::IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= bip_pkg::IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_ack   <= (w_next == bip_pkg::ACK);
            if (r_state == bip_pkg::IDLE && i_dbg_req) begin
                r_we    <= i_dbg_we;
                r_addr  <= i_dbg_addr;
                r_wdata <= i_dbg_wdata;
            end
            if (o_acc_c && !r_we) r_rdata <= i_acc_rdata;
        end
    end

    assign o_acc_we    = r_we;
    assign o_acc_addr  = r_addr;
    assign o_acc_wdata = r_wdata;
    assign o_dbg_ack   = r_ack;
    assign o_dbg_rdata = r_rdata;

endmodule

// File: rtl/bip_data_memory.sv
// Zero-wait-state data memory for the BIP CPU with saturating access counters and a sticky
// out-of-range flag. Define BIP_DMEM_DBG_EN to add the cycle-stealing debug port.
module bip_data_memory #(
    parameter int unsigned NB_ADDR   = bip_pkg::NB_ADDR,
    parameter int unsigned NB_DATA   = bip_pkg::NB_DATA,
    parameter int unsigned RAM_DEPTH = bip_pkg::RAM_DEPTH,
    parameter int unsigned NB_CNT    = bip_pkg::NB_CNT
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_ADDR-1:0] i_addr,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_WrRam,
    input  logic               i_RdRam,
    output logic [NB_DATA-1:0] o_data,
    output logic [NB_CNT-1:0]  o_rd_count,
    output logic [NB_CNT-1:0]  o_wr_count,
    output logic               o_oob_err
`ifdef BIP_DMEM_DBG_EN
    ,
    input  logic               i_dbg_req,
    input  logic               i_dbg_we,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    input  logic [NB_DATA-1:0] i_dbg_wdata,
    output logic               o_dbg_ack,
    output logic [NB_DATA-1:0] o_dbg_rdata
`endif
);

    localparam int unsigned NB_IDX = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    logic [NB_DATA-1:0] r_mem [RAM_DEPTH];
    logic [NB_CNT-1:0]  r_rd_count;
    logic [NB_CNT-1:0]  r_wr_count;
    logic               r_oob_err;

    logic              w_cpu_hit;
    logic              w_cpu_wr;
    logic [NB_IDX-1:0] w_cpu_idx;

    assign w_cpu_hit = (32'(i_addr) < RAM_DEPTH);
    assign w_cpu_idx = i_addr[NB_IDX-1:0];
    assign w_cpu_wr  = i_WrRam && w_cpu_hit;
    assign o_data    = w_cpu_hit ? r_mem[w_cpu_idx] : '0;

`ifdef BIP_DMEM_DBG_EN
    logic               w_acc_c;
    logic               w_acc_we;
    logic [NB_ADDR-1:0] w_acc_addr;
    logic [NB_DATA-1:0] w_acc_wdata;
    logic [NB_DATA-1:0] w_acc_word;
    logic               w_acc_hit;
    logic               w_dbg_wr;
    logic [NB_IDX-1:0]  w_acc_idx;

    assign w_acc_hit  = (32'(w_acc_addr) < RAM_DEPTH);
    assign w_acc_idx  = w_acc_addr[NB_IDX-1:0];
    assign w_acc_word = w_acc_hit ? r_mem[w_acc_idx] : '0;
    assign w_dbg_wr   = w_acc_c && w_acc_we && w_acc_hit;

    bip_dmem_dbg_port #(
        .NB_ADDR (NB_ADDR),
        .NB_DATA (NB_DATA)
    ) u_dbg_port (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_dbg_req   (i_dbg_req),
        .i_dbg_we    (i_dbg_we),
        .i_dbg_addr  (i_dbg_addr),
        .i_dbg_wdata (i_dbg_wdata),
        .i_cpu_busy  (i_WrRam | i_RdRam),
        .i_acc_rdata (w_acc_word),
        .o_acc_c     (w_acc_c),
        .o_acc_we    (w_acc_we),
        .o_acc_addr  (w_acc_addr),
        .o_acc_wdata (w_acc_wdata),
        .o_dbg_ack   (o_dbg_ack),
        .o_dbg_rdata (o_dbg_rdata)
    );
`endif

    // Array contents are intentionally not reset; the debug write only lands in CPU-idle cycles.
    always_ff @(posedge i_clk) begin
        if (w_cpu_wr) begin
            r_mem[w_cpu_idx] <= i_data;
        end
`ifdef BIP_DMEM_DBG_EN
        else if (w_dbg_wr) begin
            r_mem[w_acc_idx] <= w_acc_wdata;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
            r_oob_err  <= 1'b0;
        end else begin
            if (i_RdRam && (r_rd_count != '1)) r_rd_count <= r_rd_count + NB_CNT'(1);
            if (i_WrRam && (r_wr_count != '1)) r_wr_count <= r_wr_count + NB_CNT'(1);
            if ((i_RdRam || i_WrRam) && !w_cpu_hit) r_oob_err <= 1'b1;
        end
    end

    assign o_rd_count = r_rd_count;
    assign o_wr_count = r_wr_count;
    assign o_oob_err  = r_oob_err;

endmodule
